// File: rtl/vga_capture.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | vga_capture: sink-side VGA timing recovery, lock qualification and pixel    |
// | capture. Optional per-frame CRC built when CAPTURE_CRC_EN is defined.       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module vga_capture #(
  parameter int H_TOTAL    = 1586,
  parameter int V_TOTAL    = 526,
  parameter int H_START    = 286,
  parameter int H_ACTIVE   = 1219,
  parameter int V_START    = 36,
  parameter int V_ACTIVE   = 479,
  parameter int H_TOL      = 2,
  parameter int LOCK_LINES = 8
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic [3:0]  VGA_R,
  input  logic [3:0]  VGA_G,
  input  logic [3:0]  VGA_B,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic [3:0]  pix_r,
  output logic [3:0]  pix_g,
  output logic [3:0]  pix_b,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic [11:0] line_len,
  output logic [7:0]  err_count,
  output logic [15:0] frame_crc
);

  localparam logic [11:0] H_MIN   = 12'(H_TOTAL - H_TOL);
  localparam logic [11:0] H_MAX   = 12'(H_TOTAL + H_TOL);
  localparam logic [11:0] HS_C    = 12'(H_START);
  localparam logic [11:0] HE_C    = 12'(H_START + H_ACTIVE);
  localparam logic [11:0] VS_C    = 12'(V_START);
  localparam logic [11:0] VE_C    = 12'(V_START + V_ACTIVE);
  localparam logic [11:0] VT_C    = 12'(V_TOTAL);
  localparam logic [11:0] LOCK_N  = 12'(LOCK_LINES);
  localparam logic [11:0] CNT_MAX = 12'hFFF;

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  function automatic logic [11:0] sat12(input logic [11:0] v);
    return (v == CNT_MAX) ? v : v + 12'd1;
  endfunction

  // Sync and colour share one chain so they stay aligned; {HS, VS, R, G, B}.
  logic [13:0] sync1_q, sync2_q;
  logic [1:0]  hist_q;
  logic        hse_q, vse_q;
  logic [11:0] rgb1_q, rgb2_q;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sync1_q <= '1;
      sync2_q <= '1;
      hist_q  <= 2'b11;
      hse_q   <= 1'b0;
      vse_q   <= 1'b0;
      rgb1_q  <= '0;
      rgb2_q  <= '0;
    end else begin
      sync1_q <= {VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B};
      sync2_q <= sync1_q;
      hist_q  <= sync2_q[13:12];
      hse_q   <= hist_q[1] & ~sync2_q[13];
      vse_q   <= hist_q[0] & ~sync2_q[12];
      rgb1_q  <= sync2_q[11:0];
      rgb2_q  <= rgb1_q;
    end
  end

  state_t      state_q, state_d;
  logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [11:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
  logic [11:0] good_lines_q, good_lines_d;
  logic        first_frame_q, first_frame_d, frame_start_q, frame_start_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        pix_valid_q, pix_valid_d;
  logic [11:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d, pix_rgb_q, pix_rgb_d;
  logic [11:0] meas_len, frame_cnt, good_next;
  logic        line_good, lost;

  always_comb begin
    state_d       = state_q;
    h_cnt_d       = sat12(h_cnt_q);
    v_cnt_d       = v_cnt_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    good_lines_d  = good_lines_q;
    first_frame_d = first_frame_q;
    frame_start_d = 1'b0;
    err_count_d   = err_count_q;
    lost          = 1'b0;
    good_next     = good_lines_q;
    meas_len      = h_cnt_q + 12'd1;
    line_good     = (meas_len >= H_MIN) && (meas_len <= H_MAX);
    frame_cnt     = frame_lines_q + {11'd0, hse_q};

    if (hse_q) begin
      line_len_d    = meas_len;
      h_cnt_d       = '0;
      v_cnt_d       = sat12(v_cnt_q);
      frame_lines_d = sat12(frame_lines_q);
    end
    if (vse_q) begin
      v_cnt_d       = '0;
      frame_lines_d = '0;
      frame_start_d = 1'b1;
    end

    case (state_q)
      SEARCH: begin
        if (hse_q) begin
          state_d      = MEASURE;
          good_lines_d = '0;
        end
      end
      MEASURE: begin
        if (hse_q && !line_good) begin
          state_d = SEARCH;
        end else begin
          if (hse_q && (good_lines_q < LOCK_N)) good_next = good_lines_q + 12'd1;
          good_lines_d = good_next;
          if (vse_q && (good_next >= LOCK_N)) begin
            state_d       = LOCKED;
            first_frame_d = 1'b1;
          end
        end
      end
      LOCKED: begin
        // Bad line takes precedence over the frame-length check in the same cycle.
        if (hse_q && !line_good)                               lost = 1'b1;
        else if (vse_q && !first_frame_q && frame_cnt != VT_C) lost = 1'b1;
        else if (h_cnt_q == CNT_MAX)                           lost = 1'b1;
        if (vse_q) first_frame_d = 1'b0;
        if (lost) begin
          state_d     = SEARCH;
          err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
        end
      end
      default: state_d = SEARCH;
    endcase

    pix_valid_d = (state_q == LOCKED) && (h_cnt_q >= HS_C) && (h_cnt_q < HE_C)
                  && (v_cnt_q >= VS_C) && (v_cnt_q < VE_C);
    pix_x_d     = h_cnt_q - HS_C;
    pix_y_d     = v_cnt_q - VS_C;
    pix_rgb_d   = rgb2_q;
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q       <= SEARCH;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      good_lines_q  <= '0;
      first_frame_q <= 1'b0;
      frame_start_q <= 1'b0;
      err_count_q   <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      good_lines_q  <= good_lines_d;
      first_frame_q <= first_frame_d;
      frame_start_q <= frame_start_d;
      err_count_q   <= err_count_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_rgb_q     <= pix_rgb_d;
    end
  end

`ifdef CAPTURE_CRC_EN
  function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] w);
    logic [15:0] r;
    r = c;
    for (int i = 11; i >= 0; i--) begin
      r = (r[15] ^ w[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  logic [15:0] crc_acc_q, crc_acc_d, frame_crc_q, frame_crc_d;

  always_comb begin
    crc_acc_d   = crc_acc_q;
    frame_crc_d = frame_crc_q;
    if (pix_valid_q) crc_acc_d = crc12(crc_acc_q, pix_rgb_q);
    if (vse_q && state_q == LOCKED) begin
      frame_crc_d = crc_acc_q;
      crc_acc_d   = 16'hFFFF;
    end
    if (state_q != LOCKED && state_d == LOCKED) crc_acc_d = 16'hFFFF;
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      crc_acc_q   <= 16'hFFFF;
      frame_crc_q <= '0;
    end else begin
      crc_acc_q   <= crc_acc_d;
      frame_crc_q <= frame_crc_d;
    end
  end

  assign frame_crc = frame_crc_q;
`else
  assign frame_crc = 16'h0000;
`endif

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign {pix_r, pix_g, pix_b} = pix_rgb_q;
  assign pix_valid   = pix_valid_q;
  assign frame_start = frame_start_q;
  assign locked      = (state_q == LOCKED);
  assign line_len    = line_len_q;
  assign err_count   = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_capture.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_vga_capture: scoreboard bench for vga_capture on a reduced raster.       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_vga_capture;
  localparam int H_TOTAL = 40, V_TOTAL = 12, H_START = 8, H_ACTIVE = 20;
  localparam int V_START = 2, V_ACTIVE = 8, H_TOL = 2, LOCK_LINES = 4, HS_W = 4;

  logic        CLOCK_50 = 1'b0;
  logic        RESET = 1'b1;
  logic        VGA_HS = 1'b1, VGA_VS = 1'b1;
  logic [3:0]  VGA_R = '0, VGA_G = '0, VGA_B = '0;
  logic [11:0] pix_x, pix_y, line_len;
  logic [3:0]  pix_r, pix_g, pix_b;
  logic        pix_valid, frame_start, locked;
  logic [7:0]  err_count;
  logic [15:0] frame_crc;

  int          n_checks = 0, n_fail = 0, fs_count = 0, fs_base = 0;
  logic [35:0] exp_q[$];
  logic [15:0] model_crc = 16'hFFFF, last_frame_crc = 16'hFFFF, saved_crc;

  vga_capture #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .H_START(H_START), .H_ACTIVE(H_ACTIVE),
    .V_START(V_START), .V_ACTIVE(V_ACTIVE), .H_TOL(H_TOL), .LOCK_LINES(LOCK_LINES)
  ) u_dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .pix_x(pix_x), .pix_y(pix_y), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_valid(pix_valid), .frame_start(frame_start), .locked(locked),
    .line_len(line_len), .err_count(err_count), .frame_crc(frame_crc)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [11:0] w);
    logic [15:0] r;
    r = c;
    for (int i = 11; i >= 0; i--) begin
      r = (r[15] ^ w[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0] exp_crc(input logic [15:0] c);
`ifdef CAPTURE_CRC_EN
    return c;
`else
    return 16'h0000 & c;
`endif
  endfunction

  // Pixel monitor: every pix_valid cycle must match the oldest expected pixel.
  always @(posedge CLOCK_50) begin
    logic [35:0] e;
    #1;
    if (!RESET) begin
      if (frame_start) fs_count++;
      if (pix_valid) begin
        if (exp_q.size() == 0) begin
          check("pix_unexpected", 64'(pix_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("pix", {pix_x, pix_y, pix_r, pix_g, pix_b}, e);
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_50);
      VGA_HS = 1'b1;
      VGA_VS = 1'b1;
    end
  endtask

  task automatic gen_line(input int len, input int v, input bit lk, input bit solid);
    logic [11:0] hh, vv, rgb;
    for (int h = 0; h < len; h++) begin
      hh = 12'(h);
      vv = 12'(v);
      rgb = solid ? 12'hF00 : {hh[3:0], vv[3:0], hh[3:0] ^ vv[3:0]};
      @(negedge CLOCK_50);
      VGA_HS = (h >= HS_W);
      VGA_VS = (v >= 2);
      {VGA_R, VGA_G, VGA_B} = rgb;
      if (lk && h >= H_START && h < H_START + H_ACTIVE && v >= V_START && v < V_START + V_ACTIVE) begin
        exp_q.push_back({12'(h - H_START), 12'(v - V_START), rgb});
        model_crc = crc_model(model_crc, rgb);
      end
    end
  endtask

  task automatic gen_frame(input bit lk, input int len, input bit solid);
    model_crc = 16'hFFFF;
    for (int v = 0; v < V_TOTAL; v++) gen_line(len, v, lk, solid);
    last_frame_crc = model_crc;
  endtask

  task automatic do_reset();
    idle(8);
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(posedge CLOCK_50);
    #3 RESET = 1'b1;
    #1;
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_status", {28'd0, pix_valid, frame_start, line_len, err_count, frame_crc}, 64'd0);
    check("rst_pix", {pix_x, pix_y, pix_r, pix_g, pix_b}, 64'd0);
    repeat (3) @(negedge CLOCK_50);
    RESET = 1'b0;
    fs_base = fs_count;
  endtask

  initial begin
    #12;
    check("init_locked", 64'(locked), 64'd0);
    check("init_status", {28'd0, pix_valid, frame_start, line_len, err_count, frame_crc}, 64'd0);
    @(negedge CLOCK_50);
    RESET = 1'b0;

    // Nominal timing with a position-dependent colour pattern.
    for (int f = 0; f < 4; f++) begin
      gen_frame(f >= 1, H_TOTAL, 1'b0);
      if (f == 2) saved_crc = last_frame_crc;
    end
    idle(6);
    check("nom_locked", 64'(locked), 64'd1);
    check("nom_line_len", 64'(line_len), 64'(H_TOTAL));
    check("nom_err", 64'(err_count), 64'd0);
    check("nom_frame_start", 64'(fs_count - fs_base), 64'd4);
    check("nom_crc", 64'(frame_crc), 64'(exp_crc(saved_crc)));

    // Line period just outside tolerance never locks.
    do_reset();
    for (int f = 0; f < 3; f++) gen_frame(1'b0, H_TOTAL + H_TOL + 1, 1'b0);
    idle(6);
    check("long_locked", 64'(locked), 64'd0);
    check("long_line_len", 64'(line_len), 64'(H_TOTAL + H_TOL + 1));
    check("long_err", 64'(err_count), 64'd0);
    check("long_frame_start", 64'(fs_count - fs_base), 64'd3);

    // One stretched line after lock, then relock at the next VSE.
    do_reset();
    gen_frame(1'b0, H_TOTAL, 1'b0);
    gen_frame(1'b1, H_TOTAL, 1'b0);
    for (int v = 0; v < V_TOTAL; v++) begin
      gen_line((v == 3) ? H_TOTAL + 10 : H_TOTAL, v, v <= 3, 1'b0);
      if (v == 4) begin
        check("stretch_unlocked", 64'(locked), 64'd0);
        check("stretch_err", 64'(err_count), 64'd1);
        check("stretch_line_len", 64'(line_len), 64'(H_TOTAL + 10));
      end
    end
    for (int f = 0; f < 3; f++) gen_frame(1'b1, H_TOTAL, 1'b0);
    idle(6);
    check("relock_locked", 64'(locked), 64'd1);
    check("relock_err", 64'(err_count), 64'd1);

    // HS stuck high after lock: h_cnt saturates and lock is dropped.
    do_reset();
    gen_frame(1'b0, H_TOTAL, 1'b0);
    gen_frame(1'b1, H_TOTAL, 1'b0);
    for (int v = 0; v < 3; v++) gen_line(H_TOTAL, v, 1'b1, 1'b0);
    gen_line(4300, 3, 1'b1, 1'b0);
    idle(20);
    check("stuck_locked", 64'(locked), 64'd0);
    check("stuck_err", 64'(err_count), 64'd1);
    check("stuck_line_len", 64'(line_len), 64'(H_TOTAL));

    // Solid colour frames: frame CRC stays at the model value frame after frame.
    do_reset();
    gen_frame(1'b0, H_TOTAL, 1'b1);
    gen_frame(1'b1, H_TOTAL, 1'b1);
    saved_crc = last_frame_crc;
    gen_frame(1'b1, H_TOTAL, 1'b1);
    check("solid_crc_1", 64'(frame_crc), 64'(exp_crc(saved_crc)));
    saved_crc = last_frame_crc;
    gen_frame(1'b1, H_TOTAL, 1'b1);
    check("solid_crc_2", 64'(frame_crc), 64'(exp_crc(saved_crc)));
    check("solid_err", 64'(err_count), 64'd0);

    idle(8);
    check("final_drain", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
